mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the 32-bit ALU.
- Consumes the ALU result q as either the effective address (load/store) or a pass-through result (all other ops).
- Drives a single-outstanding request/ack data-memory bus and performs byte-lane steering plus load sign/zero extension.
- Presents one registered writeback beat per accepted instruction to the writeback stage.

Parameters:
- MEM_TIMEOUT, 15: cycles waited in ACCESS without mem_ack before a bus-timeout exception (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage presents an instruction
- ex_ready  out  1  stage can accept; high only in IDLE
- ex_alu_q  in  32  ALU result: address or pass-through data
- ex_store_data  in  32  rt value for stores
- ex_mem_op  in  4  0000 none, 0001 lb, 0010 lbu, 0011 lh, 0100 lhu, 0101 lw, 1001 sb, 1010 sh, 1011 sw; any other code = none
- ex_rd  in  5  destination register
- ex_wb_en  in  1  instruction writes rd
- mem_req  out  1  bus request, registered
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({q[31:2],2'b00})
- mem_be  out  4  byte enables, little-endian (be[0] = bits 7:0)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  one-cycle completion strobe
- mem_rdata  in  32  read word, valid with mem_ack
- wb_valid  out  1  one-cycle writeback beat
- wb_en  out  1  register write enable for this beat
- wb_rd  out  5  destination register
- wb_data  out  32  result
- exc_valid  out  1  one-cycle exception strobe
- exc_code  out  2  01 load misaligned, 10 store misaligned, 11 bus timeout
- exc_badaddr  out  32  full faulting ex_alu_q

Behaviour:
- Reset: every output 0, FSM in IDLE, timeout counter 0. Reset mid-ACCESS drops mem_req immediately (async) and abandons the access; no wb or exc beat is produced.
- FSM states: IDLE, ACCESS.
- A transfer is accepted when ex_valid & ex_ready.
- IDLE, accepted op = none: next cycle wb_valid=1, wb_data=ex_alu_q, wb_en=ex_wb_en, wb_rd=ex_rd. Stay IDLE, so back-to-back ops issue at one per cycle.
- IDLE, accepted load/store, aligned: next cycle mem_req=1 with addr/we/be/wdata registered. Go to ACCESS and clear the counter. Alignment rule: lh/lhu/sh need q[0]=0; lw/sw need q[1:0]=00; bytes are always aligned.
- IDLE, accepted misaligned load/store: no bus request. Next cycle exc_valid=1 with the matching code and exc_badaddr=q; wb_valid stays 0; stay IDLE.
- ACCESS: mem_req and all bus outputs are held stable. The counter increments each cycle without ack.
  - mem_ack=1: the next cycle has mem_req=0 and wb_valid=1; return to IDLE.
  - Counter reaches MEM_TIMEOUT-1 without ack: the next cycle has mem_req=0, exc_valid=1, code 11; return to IDLE.
  - Ack and timeout in the same cycle: ack wins.
- Stores: sb puts wdata={4{d[7:0]}} with be=0001<<q[1:0]. sh puts wdata={2{d[15:0]}} with be=q[1]?1100:0011. sw puts wdata=d with be=1111. On completion wb_valid=1 and wb_en=0.
- Loads: be=1111, we=0. The selected byte/half comes from lane q[1:0]. lb/lh sign-extend, lbu/lhu zero-extend. wb_en=ex_wb_en.
- wb_valid and exc_valid are never high in the same cycle; each is a single-cycle pulse.
- mem_ack while not in ACCESS is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: misaligned accesses raise exceptions as described above.
- Undefined: the misalignment check is removed and the low address bits are forced for lane selection (half uses q[1],0; word uses 00). The access proceeds normally, exc_code 01/10 is never produced, and timeout (11) remains.

Test Plan:
- ex_mem_op=0000, q=0x0000_1234 on three consecutive cycles -> three consecutive wb_valid beats with wb_data 0x1234, ex_ready constantly 1.
- lw q=0x100, ack 3 cycles after mem_req, rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, wb_data=0xDEADBEEF one cycle after ack, ex_ready low throughout ACCESS.
- lb q=0x103, rdata=0x80112233 -> wb_data=0xFFFFFF80. Same access with lbu -> wb_data=0x00000080.
- sh q=0x202, store_data=0x0000ABCD -> mem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1, wb_valid with wb_en=0 after ack.
- lh q=0x301 (macro defined) -> no mem_req, exc_valid=1, code 01, badaddr 0x301. Macro undefined -> mem_req with be=1111, lane q[1]=0 used.
- lw q=0x400, no ack, MEM_TIMEOUT=4 -> mem_req high exactly 4 cycles, then exc code 11. A separate run asserts rst_n=0 mid-ACCESS -> mem_req=0 immediately and no wb/exc beat is produced.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte-lane steering, load extension and a single-outstanding req/ack bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise low address bits are forced.
module mem_access_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_q,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wb_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_badaddr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        ex_ready_q, ex_ready_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [4:0]  rd_q, rd_d;
  logic        wben_q, wben_d;
  logic [31:0] badaddr_q, badaddr_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_en_q, wb_en_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_badaddr_q, exc_badaddr_d;

  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        misaligned, accept;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [31:0] wdata, rshift, load_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (ex_mem_op)
      4'b0001, 4'b0010: begin is_load  = 1'b1; is_byte = 1'b1; end
      4'b0011, 4'b0100: begin is_load  = 1'b1; is_half = 1'b1; end
      4'b0101:          begin is_load  = 1'b1; is_word = 1'b1; end
      4'b1001:          begin is_store = 1'b1; is_byte = 1'b1; end
      4'b1010:          begin is_store = 1'b1; is_half = 1'b1; end
      4'b1011:          begin is_store = 1'b1; is_word = 1'b1; end
      default: ;
    endcase
  end

  // Halves and words always select a naturally aligned lane; with trapping on,
  // an unaligned request never gets this far, so the forcing is invisible.
  always_comb begin
    lane = ex_alu_q[1:0];
    if (is_half) lane = {ex_alu_q[1], 1'b0};
    if (is_word) lane = 2'b00;
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = (is_half & ex_alu_q[0]) | (is_word & (|ex_alu_q[1:0]));
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    be    = 4'b1111;
    wdata = '0;
    if (is_store) begin
      if (is_byte) begin
        be    = 4'b0001 << lane;
        wdata = {4{ex_store_data[7:0]}};
      end else if (is_half) begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_store_data[15:0]}};
      end else begin
        wdata = ex_store_data;
      end
    end
  end

  always_comb begin
    rshift = mem_rdata >> {lane_q, 3'b000};
    case (op_q)
      4'b0001: load_data = {{24{rshift[7]}}, rshift[7:0]};
      4'b0010: load_data = {24'h0, rshift[7:0]};
      4'b0011: load_data = {{16{rshift[15]}}, rshift[15:0]};
      4'b0100: load_data = {16'h0, rshift[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  assign accept = ex_valid & ex_ready_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ex_ready_d    = ex_ready_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    op_d          = op_q;
    lane_d        = lane_q;
    rd_d          = rd_q;
    wben_d        = wben_q;
    badaddr_d     = badaddr_q;
    wb_valid_d    = 1'b0;
    wb_en_d       = wb_en_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    exc_valid_d   = 1'b0;
    exc_code_d    = exc_code_q;
    exc_badaddr_d = exc_badaddr_q;
    case (state_q)
      IDLE: begin
        ex_ready_d = 1'b1;
        if (accept) begin
          if (!(is_load | is_store)) begin
            wb_valid_d = 1'b1;
            wb_en_d    = ex_wb_en;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_q;
          end else if (misaligned) begin
            exc_valid_d   = 1'b1;
            exc_code_d    = is_load ? 2'b01 : 2'b10;
            exc_badaddr_d = ex_alu_q;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            ex_ready_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {ex_alu_q[31:2], 2'b00};
            mem_be_d    = be;
            mem_wdata_d = wdata;
            op_d        = ex_mem_op;
            lane_d      = lane;
            rd_d        = ex_rd;
            wben_d      = ex_wb_en & is_load;
            badaddr_d   = ex_alu_q;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d    = IDLE;
          ex_ready_d = 1'b1;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_en_d    = wben_q;
          wb_rd_d    = rd_q;
          wb_data_d  = mem_we_q ? badaddr_q : load_data;
        end else if (cnt_q == TO_LAST) begin
          state_d       = IDLE;
          ex_ready_d    = 1'b1;
          mem_req_d     = 1'b0;
          exc_valid_d   = 1'b1;
          exc_code_d    = 2'b11;
          exc_badaddr_d = badaddr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ex_ready_q    <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      op_q          <= '0;
      lane_q        <= '0;
      rd_q          <= '0;
      wben_q        <= 1'b0;
      badaddr_q     <= '0;
      wb_valid_q    <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= '0;
      exc_badaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ex_ready_q    <= ex_ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      rd_q          <= rd_d;
      wben_q        <= wben_d;
      badaddr_q     <= badaddr_d;
      wb_valid_q    <= wb_valid_d;
      wb_en_q       <= wb_en_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      exc_valid_q   <= exc_valid_d;
      exc_code_q    <= exc_code_d;
      exc_badaddr_q <= exc_badaddr_d;
    end
  end

  assign ex_ready    = ex_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_en       = wb_en_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign exc_valid   = exc_valid_q;
  assign exc_code    = exc_code_q;
  assign exc_badaddr = exc_badaddr_q;

endmodule
